// File: rtl/reg_rename_file_pkg.sv
// Shared sizing and types for the rename register file.
// Labels are ROB_ID_WIDTH+1 bits so that tag 0 means "value is final".
package reg_rename_file_pkg;

    localparam int REG_NUM      = 32;
    localparam int REG_WIDTH    = 5;
    localparam int VAL_WIDTH    = 32;
    localparam int ROB_ID_WIDTH = 3;
    localparam int ROB_SIZE     = 2 ** ROB_ID_WIDTH;
    localparam int LAB_WIDTH    = ROB_ID_WIDTH + 1;

    typedef logic [REG_WIDTH-1:0] reg_idx_t;
    typedef logic [VAL_WIDTH-1:0] val_t;
    typedef logic [LAB_WIDTH-1:0] lab_t;

endpackage

// File: rtl/reg_rename_file_rf_read_port.sv
// Combinational read port: x0 forcing and same-cycle commit bypass.
// Ports: rs/lab_rs/val_rs (stored entry), commit_* (retire bus), label/value out.
module rf_read_port
    import reg_rename_file_pkg::*;
(
    input  logic [REG_WIDTH-1:0] rs,
    input  logic [LAB_WIDTH-1:0] lab_rs,
    input  logic [VAL_WIDTH-1:0] val_rs,
    input  logic                 commit_en,
    input  logic [REG_WIDTH-1:0] commit_rd,
    input  logic [VAL_WIDTH-1:0] commit_res,
    input  logic [LAB_WIDTH-1:0] commit_lab,
    output logic [LAB_WIDTH-1:0] label,
    output logic [VAL_WIDTH-1:0] value
);

    logic is_x0;
    logic bypass;

    assign is_x0 = (rs == '0);
    // Only forward if the retiring entry is still the current producer.
    assign bypass = commit_en && (commit_rd == rs) && (lab_rs == commit_lab);

    always_comb begin
        label = lab_rs;
        value = val_rs;
        if (is_x0) begin
            label = '0;
            value = '0;
        end else if (bypass) begin
            label = '0;
            value = commit_res;
        end
    end

endmodule

// File: rtl/reg_rename_file.sv
// Architectural register file with per-register producer ROB label.
// Ports: clk/rst_in/rdy_in, rs1/rs2 reads, issue_* rename, commit_* retire, flush_in.
module reg_rename_file
    import reg_rename_file_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic [REG_WIDTH-1:0] rs1,
    input  logic [REG_WIDTH-1:0] rs2,
    output logic [LAB_WIDTH-1:0] rf_label1,
    output logic [LAB_WIDTH-1:0] rf_label2,
    output logic [VAL_WIDTH-1:0] rf_val1,
    output logic [VAL_WIDTH-1:0] rf_val2,
    input  logic                 issue_en,
    input  logic [REG_WIDTH-1:0] issue_rd,
    input  logic [LAB_WIDTH-1:0] issue_tag,
    input  logic                 commit_en,
    input  logic [REG_WIDTH-1:0] commit_rd,
    input  logic [VAL_WIDTH-1:0] commit_res,
    input  logic [LAB_WIDTH-1:0] commit_lab,
    input  logic                 flush_in
);

    val_t val_q [REG_NUM];
    lab_t lab_q [REG_NUM];

    // Entry 0 is only ever cleared, so x0 stays 0/0.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                val_q[i] <= '0;
                lab_q[i] <= '0;
            end
        end else if (rdy_in) begin
            for (int i = 1; i < REG_NUM; i++) begin
                if (commit_en && commit_rd == REG_WIDTH'(i))
                    val_q[i] <= commit_res;
                // flush > issue > commit for the label
                if (flush_in)
                    lab_q[i] <= '0;
                else if (issue_en && issue_rd == REG_WIDTH'(i))
                    lab_q[i] <= issue_tag;
                else if (commit_en && commit_rd == REG_WIDTH'(i)
                         && lab_q[i] == commit_lab)
                    lab_q[i] <= '0;
            end
        end
    end

    rf_read_port u_rp1 (
        .rs         (rs1),
        .lab_rs     (lab_q[rs1]),
        .val_rs     (val_q[rs1]),
        .commit_en  (commit_en),
        .commit_rd  (commit_rd),
        .commit_res (commit_res),
        .commit_lab (commit_lab),
        .label      (rf_label1),
        .value      (rf_val1)
    );

    rf_read_port u_rp2 (
        .rs         (rs2),
        .lab_rs     (lab_q[rs2]),
        .val_rs     (val_q[rs2]),
        .commit_en  (commit_en),
        .commit_rd  (commit_rd),
        .commit_res (commit_res),
        .commit_lab (commit_lab),
        .label      (rf_label2),
        .value      (rf_val2)
    );

endmodule

// File: tb/tb_reg_rename_file.sv
// Directed table-driven bench for reg_rename_file.
// Inputs change on negedge; reads are checked 1ns later, state moves on posedge.
module tb_reg_rename_file;

    logic        clk = 1'b0;
    logic        rst_in, rdy_in, flush_in;
    logic [4:0]  rs1, rs2;
    logic [3:0]  rf_label1, rf_label2;
    logic [31:0] rf_val1, rf_val2;
    logic        issue_en, commit_en;
    logic [4:0]  issue_rd, commit_rd;
    logic [3:0]  issue_tag, commit_lab;
    logic [31:0] commit_res;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    reg_rename_file dut (
        .clk        (clk),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .rs1        (rs1),
        .rs2        (rs2),
        .rf_label1  (rf_label1),
        .rf_label2  (rf_label2),
        .rf_val1    (rf_val1),
        .rf_val2    (rf_val2),
        .issue_en   (issue_en),
        .issue_rd   (issue_rd),
        .issue_tag  (issue_tag),
        .commit_en  (commit_en),
        .commit_rd  (commit_rd),
        .commit_res (commit_res),
        .commit_lab (commit_lab),
        .flush_in   (flush_in)
    );

    typedef struct {
        logic        rst, rdy, flush;
        logic        ie;
        logic [4:0]  ird;
        logic [3:0]  itag;
        logic        ce;
        logic [4:0]  crd;
        logic [31:0] cres;
        logic [3:0]  clab;
        logic [4:0]  r1, r2;
        logic        chk;
        logic [3:0]  el1;
        logic [31:0] ev1;
        logic [3:0]  el2;
        logic [31:0] ev2;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        logic rst, logic rdy, logic flush,
        logic ie, logic [4:0] ird, logic [3:0] itag,
        logic ce, logic [4:0] crd, logic [31:0] cres, logic [3:0] clab,
        logic [4:0] r1, logic [4:0] r2, logic chk,
        logic [3:0] el1, logic [31:0] ev1,
        logic [3:0] el2, logic [31:0] ev2);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.flush = flush;
        v.ie = ie; v.ird = ird; v.itag = itag;
        v.ce = ce; v.crd = crd; v.cres = cres; v.clab = clab;
        v.r1 = r1; v.r2 = r2; v.chk = chk;
        v.el1 = el1; v.ev1 = ev1; v.el2 = el2; v.ev2 = ev2;
        return v;
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        @(negedge clk);
        rst_in     = v.rst;
        rdy_in     = v.rdy;
        flush_in   = v.flush;
        issue_en   = v.ie;
        issue_rd   = v.ird;
        issue_tag  = v.itag;
        commit_en  = v.ce;
        commit_rd  = v.crd;
        commit_res = v.cres;
        commit_lab = v.clab;
        rs1        = v.r1;
        rs2        = v.r2;
        #1;
    endtask

    task automatic run(string tag, vec_t v);
        drive(v);
        if (v.chk) begin
            check({tag, " lab1"}, 32'(rf_label1), 32'(v.el1));
            check({tag, " val1"}, rf_val1, v.ev1);
            check({tag, " lab2"}, 32'(rf_label2), 32'(v.el2));
            check({tag, " val2"}, rf_val2, v.ev2);
        end
    endtask

    initial begin
        //            rst rdy fl ie ird itag ce crd cres clab r1 r2 chk el1 ev1 el2 ev2
        tbl.push_back(mk(1,1,0, 0,0,0, 0,0,0,0,       0,0, 0, 0,0,0,0));
        tbl.push_back(mk(0,1,0, 0,0,0, 0,0,0,0,       5,31,1, 0,0,0,0));
        tbl.push_back(mk(0,1,0, 0,0,0, 0,0,0,0,       1,2, 1, 0,0,0,0));
        // issue x5 tag3 then commit
        tbl.push_back(mk(0,1,0, 1,5,3, 0,0,0,0,       5,0, 1, 0,0,0,0));
        tbl.push_back(mk(0,1,0, 0,0,0, 0,0,0,0,       5,5, 1, 3,0,3,0));
        tbl.push_back(mk(0,1,0, 0,0,0, 1,5,32'hDEAD,3,5,5, 1, 0,32'hDEAD,0,32'hDEAD));
        tbl.push_back(mk(0,1,0, 0,0,0, 0,0,0,0,       5,0, 1, 0,32'hDEAD,0,0));
        // older commit must not clear a younger rename
        tbl.push_back(mk(0,1,0, 1,5,3, 0,0,0,0,       5,0, 1, 0,32'hDEAD,0,0));
        tbl.push_back(mk(0,1,0, 1,5,4, 0,0,0,0,       5,0, 1, 3,32'hDEAD,0,0));
        tbl.push_back(mk(0,1,0, 0,0,0, 1,5,7,3,       5,0, 1, 4,32'hDEAD,0,0));
        tbl.push_back(mk(0,1,0, 0,0,0, 0,0,0,0,       5,0, 1, 4,7,0,0));
        // same-cycle issue and commit on x6
        tbl.push_back(mk(0,1,0, 1,6,2, 0,0,0,0,       6,0, 1, 0,0,0,0));
        tbl.push_back(mk(0,1,0, 1,6,5, 1,6,9,2,       6,0, 1, 0,9,0,0));
        tbl.push_back(mk(0,1,0, 0,0,0, 0,0,0,0,       6,5, 1, 5,9,4,7));
        // rename x1..x4, then flush with commit and ignored issue
        tbl.push_back(mk(0,1,0, 1,1,1, 0,0,0,0,       0,0, 0, 0,0,0,0));
        tbl.push_back(mk(0,1,0, 1,2,2, 0,0,0,0,       0,0, 0, 0,0,0,0));
        tbl.push_back(mk(0,1,0, 1,3,3, 0,0,0,0,       0,0, 0, 0,0,0,0));
        tbl.push_back(mk(0,1,0, 1,4,4, 0,0,0,0,       1,2, 1, 1,0,2,0));
        tbl.push_back(mk(0,1,1, 1,7,6, 1,2,32'h55,2,  2,3, 1, 0,32'h55,3,0));
        tbl.push_back(mk(0,1,0, 0,0,0, 0,0,0,0,       2,4, 1, 0,32'h55,0,0));
        tbl.push_back(mk(0,1,0, 0,0,0, 0,0,0,0,       5,6, 1, 0,7,0,9));
        tbl.push_back(mk(0,1,0, 0,0,0, 0,0,0,0,       7,1, 1, 0,0,0,0));
        // x0 writes ignored, rdy_in low holds state
        tbl.push_back(mk(0,1,0, 1,0,2, 1,0,32'h1234,0,0,0, 1, 0,0,0,0));
        tbl.push_back(mk(0,0,0, 1,7,1, 1,7,32'hAA,1,  0,7, 1, 0,0,0,0));
        tbl.push_back(mk(0,1,0, 0,0,0, 0,0,0,0,       0,7, 1, 0,0,0,0));
        tbl.push_back(mk(0,1,0, 1,3,5, 0,0,0,0,       0,0, 0, 0,0,0,0));
        tbl.push_back(mk(0,0,1, 0,0,0, 0,0,0,0,       3,0, 1, 5,0,0,0));
        tbl.push_back(mk(0,1,0, 0,0,0, 0,0,0,0,       3,2, 1, 5,0,0,32'h55));
        // reset overrides simultaneous issue/commit
        tbl.push_back(mk(1,1,0, 1,9,2, 1,2,32'h77,0,  3,0, 1, 5,0,0,0));
        tbl.push_back(mk(0,1,0, 0,0,0, 0,0,0,0,       3,2, 1, 0,0,0,0));
        tbl.push_back(mk(0,1,0, 0,0,0, 0,0,0,0,       9,0, 1, 0,0,0,0));

        foreach (tbl[i])
            run($sformatf("row%0d", i), tbl[i]);

        // Highest tag (8): a commit with a different label only writes the value.
        run("wrap0", mk(0,1,0, 1,8,8, 0,0,0,0,   8,0, 1, 0,0,0,0));
        run("wrap1", mk(0,1,0, 0,0,0, 1,8,3,0,   8,0, 1, 8,0,0,0));
        run("wrap2", mk(0,1,0, 0,0,0, 0,0,0,0,   8,0, 1, 8,3,0,0));
        run("wrap3", mk(0,1,0, 0,0,0, 1,8,4,8,   8,8, 1, 0,4,0,4));
        run("wrap4", mk(0,1,0, 0,0,0, 0,0,0,0,   8,0, 1, 0,4,0,0));

        // Tag reuse after retire: x8 renamed again with tag 8.
        run("reuse0", mk(0,1,0, 1,8,8, 0,0,0,0,  8,0, 1, 0,4,0,0));
        run("reuse1", mk(0,1,0, 0,0,0, 0,0,0,0,  8,0, 1, 8,4,0,0));

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
